// File: rtl/ctrl_fsm_multicycle.sv
// Multicycle control sequencer: accepts one instruction, evaluates its condition
// against NZCV, then walks DECODE/EXEC/MEM/WB/BRANCH driving registered datapath controls.
module ctrl_fsm_multicycle #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    input  logic [3:0]  flags,
    input  logic        mem_ack,
    output logic        instr_ready,
    output logic [1:0]  ImmSrc,
    output logic        ALUSrc,
    output logic        FlagWrite,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        PCSrc,
    output logic        instr_done,
    output logic        error
);

    localparam int unsigned COND_W  = 4;
    localparam int unsigned OP_W    = 2;
    localparam int unsigned FUNCT_W = 6;
    localparam int unsigned CNT_W   = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    localparam logic [OP_W-1:0]   OP_DP    = 2'b00;
    localparam logic [OP_W-1:0]   OP_MEM   = 2'b01;
    localparam logic [OP_W-1:0]   OP_BR    = 2'b10;
    localparam logic [OP_W-1:0]   OP_UNDEF = 2'b11;
    localparam logic [COND_W-1:0] COND_NV  = 4'b1111;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_BRANCH
    } state_t;

    typedef struct packed {
        logic       ready;
        logic [1:0] imm_src;
        logic       alu_src;
        logic       flag_write;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       pc_src;
        logic       done;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{ready: 1'b1, default: '0};

    // ARM condition evaluation; NV is trapped as illegal before this matters.
    function automatic logic cond_pass(input logic [COND_W-1:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        logic pass;
        n = nzcv[3];
        z = nzcv[2];
        c = nzcv[1];
        v = nzcv[0];
        unique case (cond)
            4'h0:    pass = z;
            4'h1:    pass = !z;
            4'h2:    pass = c;
            4'h3:    pass = !c;
            4'h4:    pass = n;
            4'h5:    pass = !n;
            4'h6:    pass = v;
            4'h7:    pass = !v;
            4'h8:    pass = c && !z;
            4'h9:    pass = !c || z;
            4'hA:    pass = (n == v);
            4'hB:    pass = (n != v);
            4'hC:    pass = !z && (n == v);
            4'hD:    pass = z || (n != v);
            4'hE:    pass = 1'b1;
            default: pass = 1'b0;
        endcase
        return pass;
    endfunction

    // Immediate/operand selects held for the whole life of an instruction.
    function automatic ctrl_t hold_ctrl(input logic [OP_W-1:0] op, input logic [FUNCT_W-1:0] funct);
        ctrl_t c;
        c = '0;
        c.imm_src = (op == OP_UNDEF) ? 2'b00 : op;
        c.alu_src = (op == OP_DP) ? funct[5] : (op == OP_MEM);
        return c;
    endfunction

    function automatic logic is_compare(input logic [FUNCT_W-1:0] funct);
        return (funct[4:1] == 4'b1010) || (funct[4:1] == 4'b1011);
    endfunction

    state_t               state_q, state_d;
    logic [OP_W-1:0]      op_q, op_d;
    logic [FUNCT_W-1:0]   funct_q, funct_d;
    logic                 skip_q, skip_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 error_q, error_d;
    ctrl_t                ctrl_q, ctrl_d;

    logic                 new_illegal;
    logic                 new_skip;
    logic                 unused_instr;

    assign new_illegal  = (instr[31:28] == COND_NV) || (instr[27:26] == OP_UNDEF);
    assign new_skip     = new_illegal || !cond_pass(instr[31:28], flags);
    assign unused_instr = ^instr[19:0];

    // Next-state and next-control decode; controls are registered alongside the state.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        funct_d = funct_q;
        skip_d  = skip_q;
        cnt_d   = cnt_q;
        error_d = error_q;
        ctrl_d  = CTRL_IDLE;

        unique case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    op_d        = instr[27:26];
                    funct_d     = instr[25:20];
                    skip_d      = new_skip;
                    error_d     = error_q | new_illegal;
                    state_d     = S_DECODE;
                    ctrl_d      = hold_ctrl(instr[27:26], instr[25:20]);
                    ctrl_d.done = new_skip;
                end
            end
            S_DECODE: begin
                if (skip_q) begin
                    state_d = S_IDLE;
                end else begin
                    state_d           = S_EXEC;
                    ctrl_d            = hold_ctrl(op_q, funct_q);
                    ctrl_d.flag_write = (op_q == OP_DP) && funct_q[0];
                    ctrl_d.done       = (op_q == OP_DP) && is_compare(funct_q);
                end
            end
            S_EXEC: begin
                unique case (op_q)
                    OP_DP: begin
                        if (!is_compare(funct_q)) begin
                            state_d          = S_WB;
                            ctrl_d           = hold_ctrl(op_q, funct_q);
                            ctrl_d.reg_write = 1'b1;
                            ctrl_d.done      = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                    OP_MEM: begin
                        state_d          = S_MEM;
                        cnt_d            = '0;
                        ctrl_d           = hold_ctrl(op_q, funct_q);
                        ctrl_d.mem_read  = funct_q[0];
                        ctrl_d.mem_write = !funct_q[0];
                    end
                    OP_BR: begin
                        state_d       = S_BRANCH;
                        ctrl_d        = hold_ctrl(op_q, funct_q);
                        ctrl_d.pc_src = 1'b1;
                        ctrl_d.done   = 1'b1;
                    end
                    default: state_d = S_IDLE;
                endcase
            end
            S_MEM: begin
                if (mem_ack) begin
                    if (funct_q[0]) begin
                        state_d          = S_WB;
                        ctrl_d           = hold_ctrl(op_q, funct_q);
                        ctrl_d.reg_write = 1'b1;
                        ctrl_d.done      = 1'b1;
                    end else begin
                        state_d     = S_IDLE;
                        ctrl_d.done = 1'b1;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    // Wait budget spent: abort without writeback and latch the fault.
                    state_d     = S_IDLE;
                    error_d     = 1'b1;
                    ctrl_d.done = 1'b1;
                end else begin
                    cnt_d            = cnt_q + CNT_W'(1);
                    ctrl_d           = hold_ctrl(op_q, funct_q);
                    ctrl_d.mem_read  = funct_q[0];
                    ctrl_d.mem_write = !funct_q[0];
                end
            end
            S_WB:     state_d = S_IDLE;
            S_BRANCH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            funct_q <= '0;
            skip_q  <= 1'b0;
            cnt_q   <= '0;
            error_q <= 1'b0;
            ctrl_q  <= CTRL_IDLE;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            funct_q <= funct_d;
            skip_q  <= skip_d;
            cnt_q   <= cnt_d;
            error_q <= error_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign instr_ready = ctrl_q.ready;
    assign ImmSrc      = ctrl_q.imm_src;
    assign ALUSrc      = ctrl_q.alu_src;
    assign FlagWrite   = ctrl_q.flag_write;
    assign MemRead     = ctrl_q.mem_read;
    assign MemWrite    = ctrl_q.mem_write;
    assign RegWrite    = ctrl_q.reg_write;
    assign PCSrc       = ctrl_q.pc_src;
    assign instr_done  = ctrl_q.done;
    assign error       = error_q;

    // Structural invariants of the control word.
    a_mem_excl: assert property (@(posedge clk) disable iff (reset) !(MemRead && MemWrite));
    a_idle_quiet: assert property (@(posedge clk) disable iff (reset)
        instr_ready |-> !(MemRead || MemWrite || RegWrite || PCSrc || FlagWrite));

endmodule

// File: tb/tb_ctrl_fsm_multicycle.sv
// Scoreboard bench for ctrl_fsm_multicycle: expected retire profiles are queued at issue
// and compared against observed enables when the controller pulses instr_done.
module tb_ctrl_fsm_multicycle;

    typedef struct {
        int         id;
        int         lat;
        int         fw;
        int         rd;
        int         wr;
        int         rw;
        int         pc;
        logic [1:0] imm;
        logic       alu;
        logic       chk_sel;
        logic       err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic [31:0] instr;
    logic [3:0]  flags;
    logic        mem_ack = 1'b0;
    logic        instr_ready;
    logic [1:0]  ImmSrc;
    logic        ALUSrc;
    logic        FlagWrite;
    logic        MemRead;
    logic        MemWrite;
    logic        RegWrite;
    logic        PCSrc;
    logic        instr_done;
    logic        error;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];
    exp_t cur;
    int   ack_at_g = -1;
    int   mem_k = 0;
    logic mon_busy = 1'b0;
    int   mon_cyc, c_fw, c_rd, c_wr, c_rw, c_pc, c_sel_bad, c_idle_bad;

    ctrl_fsm_multicycle #(.MEM_TIMEOUT(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr       (instr),
        .flags       (flags),
        .mem_ack     (mem_ack),
        .instr_ready (instr_ready),
        .ImmSrc      (ImmSrc),
        .ALUSrc      (ALUSrc),
        .FlagWrite   (FlagWrite),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .RegWrite    (RegWrite),
        .PCSrc       (PCSrc),
        .instr_done  (instr_done),
        .error       (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    function automatic exp_t mk(input int id, input int lat, input int fw, input int rd,
                                input int wr, input int rw, input int pc, input logic [1:0] imm,
                                input logic alu, input logic chk_sel, input logic err);
        exp_t e;
        e.id = id; e.lat = lat; e.fw = fw; e.rd = rd; e.wr = wr; e.rw = rw; e.pc = pc;
        e.imm = imm; e.alu = alu; e.chk_sel = chk_sel; e.err = err;
        return e;
    endfunction

    // Memory model: raise mem_ack in the ack_at_g-th MEM cycle (0-based); -1 never acks.
    always @(negedge clk) begin
        if (MemRead || MemWrite) begin
            mem_ack = (mem_k == ack_at_g);
            mem_k++;
        end else begin
            mem_ack = 1'b0;
            mem_k   = 0;
        end
    end

    // Monitor: profile the in-flight instruction, pop and compare on retire.
    always @(negedge clk) begin
        if (reset) begin
            mon_busy = 1'b0;
            exp_q.delete();
        end else begin
            if (mon_busy) begin
                mon_cyc++;
                if (FlagWrite) c_fw++;
                if (MemRead)   c_rd++;
                if (MemWrite)  c_wr++;
                if (RegWrite)  c_rw++;
                if (PCSrc)     c_pc++;
                if (!instr_ready) begin
                    if (exp_q.size() > 0 && (ImmSrc != exp_q[0].imm || ALUSrc != exp_q[0].alu))
                        c_sel_bad++;
                end else if (ImmSrc != 2'b00 || ALUSrc) begin
                    c_idle_bad++;
                end
                if (instr_done) begin
                    mon_busy = 1'b0;
                    check("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) begin
                        cur = exp_q.pop_front();
                        check($sformatf("i%0d_latency", cur.id), 32'(mon_cyc), 32'(cur.lat));
                        check($sformatf("i%0d_flagwrite", cur.id), 32'(c_fw), 32'(cur.fw));
                        check($sformatf("i%0d_memread", cur.id), 32'(c_rd), 32'(cur.rd));
                        check($sformatf("i%0d_memwrite", cur.id), 32'(c_wr), 32'(cur.wr));
                        check($sformatf("i%0d_regwrite", cur.id), 32'(c_rw), 32'(cur.rw));
                        check($sformatf("i%0d_pcsrc", cur.id), 32'(c_pc), 32'(cur.pc));
                        check($sformatf("i%0d_idle_sel", cur.id), 32'(c_idle_bad), 32'd0);
                        check($sformatf("i%0d_error", cur.id), 32'(error), 32'(cur.err));
                        if (cur.chk_sel)
                            check($sformatf("i%0d_sel_hold", cur.id), 32'(c_sel_bad), 32'd0);
                    end
                end
            end else if (instr_done) begin
                check("stray_done", 32'(instr_done), 32'd0);
            end
            if (instr_valid && instr_ready) begin
                mon_busy = 1'b1;
                mon_cyc = 0; c_fw = 0; c_rd = 0; c_wr = 0; c_rw = 0; c_pc = 0;
                c_sel_bad = 0; c_idle_bad = 0;
            end
        end
    end

    task automatic send(input logic [31:0] word, input logic [3:0] nzcv, input int ack_at,
                        input exp_t e);
        int guard;
        guard = 0;
        while (!instr_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        ack_at_g = ack_at;
        exp_q.push_back(e);
        instr = word;
        flags = nzcv;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        instr = $urandom;
        flags = 4'($urandom);
    endtask

    task automatic issue(input logic [31:0] word, input logic [3:0] nzcv, input int ack_at,
                         input logic noise, input exp_t e);
        int guard;
        send(word, nzcv, ack_at, e);
        if (noise) begin
            instr_valid = 1'b1;
            instr = 32'hF000_0000;
            @(posedge clk); #1;
            @(posedge clk); #1;
            instr_valid = 1'b0;
        end
        guard = 0;
        while (mon_busy && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        check($sformatf("i%0d_retired", e.id), 32'(mon_busy), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        instr_valid = 1'b0;
        instr = '0;
        flags = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(instr_ready), 32'd1);
        check("rst_outputs", 32'({ImmSrc, ALUSrc, FlagWrite, MemRead, MemWrite, RegWrite, PCSrc, instr_done}), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        @(posedge clk); #1;

        //    instr         flags    ack noise id lat fw rd wr rw pc imm   alu chk err
        issue(32'hE3A01005, 4'b0000, -1, 1'b0, mk(1,  3, 0, 0, 0, 1, 0, 2'b00, 1, 1, 0));
        issue(32'h1A000002, 4'b0100, -1, 1'b0, mk(2,  1, 0, 0, 0, 0, 0, 2'b10, 0, 1, 0));
        issue(32'h1A000002, 4'b0000, -1, 1'b0, mk(3,  3, 0, 0, 0, 0, 1, 2'b10, 0, 1, 0));
        issue(32'hE5912004, 4'b0000,  2, 1'b1, mk(4,  6, 0, 3, 0, 1, 0, 2'b01, 1, 1, 0));
        issue(32'hE5912004, 4'b0000,  0, 1'b0, mk(5,  4, 0, 1, 0, 1, 0, 2'b01, 1, 1, 0));
        issue(32'hE5812004, 4'b0000,  1, 1'b0, mk(6,  5, 0, 0, 2, 0, 0, 2'b01, 1, 1, 0));
        issue(32'hE3510000, 4'b0000, -1, 1'b0, mk(7,  2, 1, 0, 0, 0, 0, 2'b00, 1, 1, 0));
        issue(32'hE0912003, 4'b0000, -1, 1'b0, mk(8,  3, 1, 0, 0, 1, 0, 2'b00, 0, 1, 0));
        issue(32'hE1710002, 4'b0000, -1, 1'b0, mk(9,  2, 1, 0, 0, 0, 0, 2'b00, 0, 1, 0));
        issue(32'hC3A01005, 4'b1000, -1, 1'b0, mk(10, 1, 0, 0, 0, 0, 0, 2'b00, 1, 1, 0));
        issue(32'hB3A01005, 4'b1000, -1, 1'b0, mk(11, 3, 0, 0, 0, 1, 0, 2'b00, 1, 1, 0));
        issue(32'h83A01005, 4'b0010, -1, 1'b0, mk(12, 3, 0, 0, 0, 1, 0, 2'b00, 1, 1, 0));
        issue(32'h93A01005, 4'b0010, -1, 1'b0, mk(13, 1, 0, 0, 0, 0, 0, 2'b00, 1, 1, 0));
        issue(32'h0A000002, 4'b0100, -1, 1'b0, mk(14, 3, 0, 0, 0, 0, 1, 2'b10, 0, 1, 0));
        issue(32'hE5812004, 4'b0000, -1, 1'b0, mk(15, 7, 0, 0, 4, 0, 0, 2'b01, 1, 1, 1));
        issue(32'hE3510000, 4'b0000, -1, 1'b0, mk(16, 2, 1, 0, 0, 0, 0, 2'b00, 1, 1, 1));
        issue(32'hEC000000, 4'b0000, -1, 1'b0, mk(17, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1));
        issue(32'hF3A01005, 4'b0000, -1, 1'b0, mk(18, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1));

        // Abort a load stuck in MEM with reset.
        send(32'hE5912004, 4'b0000, -1, mk(19, 0, 0, 0, 0, 0, 0, 2'b01, 1, 1, 1));
        for (int i = 0; i < 10 && !MemRead; i++) begin
            @(posedge clk); #1;
        end
        check("rstmem_in_mem", 32'(MemRead), 32'd1);
        check("rstmem_err_before", 32'(error), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rstmem_ready", 32'(instr_ready), 32'd1);
        check("rstmem_enables", 32'({FlagWrite, MemRead, MemWrite, RegWrite, PCSrc}), 32'd0);
        check("rstmem_sel", 32'({ImmSrc, ALUSrc}), 32'd0);
        check("rstmem_done", 32'(instr_done), 32'd0);
        check("rstmem_error", 32'(error), 32'd0);
        @(posedge clk); #1;

        issue(32'hE3A01005, 4'b0000, -1, 1'b0, mk(20, 3, 0, 0, 0, 1, 0, 2'b00, 1, 1, 0));
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
